// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream bundle for the 2x2 max-pool stage.
// master drives i_data/valid_in; slave drives o_data/valid_out/frame_done.
interface maxpool2x2_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output i_data, valid_in,
    input  o_data, valid_out, frame_done
  );

  modport slave (
    input  i_data, valid_in,
    output o_data, valid_out, frame_done
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max pooling over a row-major post-ReLU float stream.
// Ports: clk, rst (async high), bus (slave: i_data/valid_in in, o_data/valid_out/frame_done out).
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224
) (
  input  logic                clk,
  input  logic                rst,
  maxpool2x2_stream_if.slave  bus
);
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int HW = IMG_WIDTH / 2;
  localparam int AW = (HW > 1) ? $clog2(HW) : 1;
  localparam int LAST_OR = (IMG_HEIGHT / 2) * 2 - 1;
  localparam int LAST_OC = (IMG_WIDTH / 2) * 2 - 1;

  typedef logic [DATA_WIDTH-1:0] pix_t;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  pix_t          r_pair;
  pix_t          r_odata;
  logic          r_valid;
  logic          r_done;
  pix_t          r_lb [HW];

  pix_t          w_pix;
  pix_t          w_lb_rd;
  pix_t          w_max2;
  pix_t          w_max3;
  logic [AW-1:0] w_addr;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_skip_row;
  logic          w_last_out;

  // Non-negative floats order the same as their magnitude bits; ties keep a.
  function automatic pix_t f_max(input pix_t a, input pix_t b);
    return (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
  endfunction

  // Negative inputs cannot survive ReLU; treat them as +0.
  assign w_pix      = bus.i_data[DATA_WIDTH-1] ? '0 : bus.i_data;
  assign w_addr     = AW'(r_col >> 1);
  assign w_lb_rd    = r_lb[w_addr];
  assign w_max2     = f_max(r_pair, w_pix);
  assign w_max3     = f_max(w_lb_rd, w_max2);
  assign w_last_col = (r_col == CW'(IMG_WIDTH - 1));
  assign w_last_row = (r_row == RW'(IMG_HEIGHT - 1));
  // With an odd height the final (even-indexed) row has no partner row.
  assign w_skip_row = ((IMG_HEIGHT % 2) == 1) && w_last_row;
  assign w_last_out = (r_row == RW'(LAST_OR)) &&
                      (r_col == CW'(LAST_OC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_pair  <= '0;
      r_odata <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (bus.valid_in) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        // An odd-width trailing column lands here too; it is never paired.
        if (!r_col[0]) begin
          r_pair <= w_pix;
        end else if (r_row[0]) begin
          r_odata <= w_max3;
          r_valid <= 1'b1;
          r_done  <= w_last_out;
        end
      end
    end
  end

  // Line buffer holds the even-row pair maxima; written before every read.
  always_ff @(posedge clk) begin
    if (!rst && bus.valid_in && r_col[0] && !r_row[0] && !w_skip_row) begin
      r_lb[w_addr] <= w_max2;
    end
  end

  assign bus.o_data     = r_odata;
  assign bus.valid_out  = r_valid;
  assign bus.frame_done = r_done;
endmodule
